// File: rtl/branch_predictor.sv
// Gshare direction predictor with a direct-mapped BTB and saturating branch/mispredict counters.
// Lookup is combinational from the fetch PC; resolution updates land on the next rising edge.
module branch_predictor #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 32,
  parameter int unsigned PHT_ENTRIES = 64,
  parameter int unsigned HIST_BITS   = 6,
  parameter int unsigned CNT_BITS    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [XLEN-1:0]                pc,
  output logic                           pred_taken,
  output logic [XLEN-1:0]                pred_target,
  output logic [$clog2(PHT_ENTRIES)-1:0] pred_pht_idx,
  input  logic                           update_valid,
  input  logic [XLEN-1:0]                update_pc,
  input  logic [$clog2(PHT_ENTRIES)-1:0] update_pht_idx,
  input  logic                           update_taken,
  input  logic [XLEN-1:0]                update_target,
  input  logic                           update_mispredict,
  output logic [CNT_BITS-1:0]            branch_cnt,
  output logic [CNT_BITS-1:0]            mispredict_cnt
);

  localparam int unsigned BTB_IW = $clog2(BTB_ENTRIES);
  localparam int unsigned PHT_IW = $clog2(PHT_ENTRIES);
  localparam int unsigned TAG_W  = XLEN - BTB_IW - 2;

  logic                 r_btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]     r_btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]      r_btb_target [BTB_ENTRIES];
  logic [1:0]           r_pht        [PHT_ENTRIES];
  logic [HIST_BITS-1:0] r_bhr;
  logic [CNT_BITS-1:0]  r_branch_cnt;
  logic [CNT_BITS-1:0]  r_mispredict_cnt;

  logic [BTB_IW-1:0]    w_btb_idx;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_hit;
  logic [PHT_IW-1:0]    w_hist_ext;
  logic [PHT_IW-1:0]    w_pht_idx;
  logic [BTB_IW-1:0]    w_upd_btb_idx;
  logic [TAG_W-1:0]     w_upd_tag;
  logic [1:0]           w_pht_cur;
  logic [1:0]           w_pht_next;
  logic                 w_unused_lsbs;

  assign w_unused_lsbs = ^{pc[1:0], update_pc[1:0]};

  assign w_btb_idx  = pc[BTB_IW+1:2];
  assign w_tag      = pc[XLEN-1:BTB_IW+2];
  assign w_hit      = r_btb_valid[w_btb_idx] && (r_btb_tag[w_btb_idx] == w_tag);
  assign w_hist_ext = PHT_IW'(r_bhr);
  assign w_pht_idx  = pc[PHT_IW+1:2] ^ w_hist_ext;

  assign pred_pht_idx = w_pht_idx;
  assign pred_taken   = w_hit && r_pht[w_pht_idx][1];
  assign pred_target  = pred_taken ? r_btb_target[w_btb_idx] : pc + XLEN'(4);

  assign w_upd_btb_idx = update_pc[BTB_IW+1:2];
  assign w_upd_tag     = update_pc[XLEN-1:BTB_IW+2];
  assign w_pht_cur     = r_pht[update_pht_idx];

  always_comb begin
    w_pht_next = w_pht_cur;
    if (update_taken) begin
      if (w_pht_cur != 2'b11) w_pht_next = w_pht_cur + 2'b01;
    end else begin
      if (w_pht_cur != 2'b00) w_pht_next = w_pht_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) r_btb_valid[i] <= 1'b0;
      for (int unsigned i = 0; i < PHT_ENTRIES; i++) r_pht[i] <= 2'b01;
      r_bhr            <= '0;
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else if (update_valid) begin
      r_pht[update_pht_idx] <= w_pht_next;
      if (update_taken) r_btb_valid[w_upd_btb_idx] <= 1'b1;
      // Truncating cast keeps the newest HIST_BITS outcomes, including the 1-bit case.
      r_bhr <= HIST_BITS'({r_bhr, update_taken});
      if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + CNT_BITS'(1);
      if (update_mispredict && (r_mispredict_cnt != '1))
        r_mispredict_cnt <= r_mispredict_cnt + CNT_BITS'(1);
    end
  end

  // Tag/target storage is qualified by r_btb_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (update_valid && update_taken) begin
      r_btb_tag[w_upd_btb_idx]    <= w_upd_tag;
      r_btb_target[w_upd_btb_idx] <= update_target;
    end
  end

  assign branch_cnt     = r_branch_cnt;
  assign mispredict_cnt = r_mispredict_cnt;

endmodule
